xcore_gnrl_skid_stage: RTL

- Elastic pipeline register for the Xcore pipeline.
- Upstream side is the consumer of a valid/ready handshake; downstream side is the producer.
- Decouples stalls between adjacent pipe stages with a 2-entry (main + skid) buffer.
- Gives full throughput (1 transfer/cycle) while keeping all handshake outputs registered, so there is no combinational ready path.

---
 rtl/xcore_gnrl_skid_stage.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/xcore_gnrl_skid_stage.sv
// -----------------------------------------------------------------------------
// xcore_gnrl_skid_stage
//
// Elastic pipeline register for the Xcore pipeline. It takes a valid/ready
// stream on its upstream side and re-issues it downstream. A two-entry buffer
// (main + skid) sustains one transfer per cycle. Both handshake outputs come
// straight from the state flops, so there is no combinational path from o_rdy
// to i_rdy or from i_vld to o_vld.
//
// Build option:
//   XCORE_SKID_FLUSH_EN - adds the synchronous 'flush' input. When flush is
//                         high at an edge, buffered entries are dropped and the
//                         stage returns to EMPTY. This is used for pipeline
//                         kill on a branch or exception.
//
// Parameters:
//   DW     - payload width in bits (default 8)
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   i_vld  - upstream payload valid
//   i_rdy  - stage can accept an upstream payload
//   i_dat  - upstream payload
//   o_vld  - downstream payload valid
//   o_rdy  - downstream accepts the payload
//   o_dat  - downstream payload (the main register)
//   flush  - synchronous flush (only with XCORE_SKID_FLUSH_EN)
//
// State | meaning
// ------+-------------------------------------------------------------
// EMPTY | no entry held;            o_vld=0, i_rdy=1
// BUSY  | main holds one entry;     o_vld=1, i_rdy=1
// FULL  | main + skid hold two;     o_vld=1, i_rdy=0
// -----------------------------------------------------------------------------
module xcore_gnrl_skid_stage #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat
`ifdef XCORE_SKID_FLUSH_EN
    ,
    input  logic          flush
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_BUSY  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;
    logic [DW-1:0] main_d;

    logic          main_ld;
    logic          main_from_skid;
    logic          skid_ld;

    logic          in_fire;
    logic          out_fire;
    logic          flush_act;

`ifdef XCORE_SKID_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // Both handshake outputs are decoded from the state flops only. The unused
    // encoding decodes to neither valid nor ready, so nothing is accepted or
    // issued during the single cycle before it recovers to EMPTY.
    assign o_vld = (state == ST_BUSY) || (state == ST_FULL);
    assign i_rdy = (state == ST_EMPTY) || (state == ST_BUSY);
    assign o_dat = main_q;

    assign in_fire  = i_vld & i_rdy;
    assign out_fire = o_vld & o_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;

        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_ld   = 1'b1;
                    state_nxt = ST_BUSY;
                end
            end

            ST_BUSY: begin
                if (in_fire && out_fire) begin
                    // Pass-through: the entry leaving is replaced in place,
                    // and the skid register stays unused.
                    main_ld   = 1'b1;
                    state_nxt = ST_BUSY;
                end else if (in_fire) begin
                    skid_ld   = 1'b1;
                    state_nxt = ST_FULL;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end

            ST_FULL: begin
                // i_rdy is low here, so only the downstream side can move.
                if (out_fire) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_BUSY;
                end
            end

            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase

        // A flush discards both entries and wins over any handshake in the same
        // cycle. The data registers keep their old contents; they carry no
        // meaning while o_vld is low.
        if (flush_act) begin
            state_nxt      = ST_EMPTY;
            main_ld        = 1'b0;
            main_from_skid = 1'b0;
            skid_ld        = 1'b0;
        end
    end

    assign main_d = main_from_skid ? skid_q : i_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
        end else if (main_ld) begin
            main_q <= main_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else if (skid_ld) begin
            skid_q <= i_dat;
        end
    end

endmodule
